instruction_fetch_unit: RTL

Sequential front end that supplies 32-bit LEGv8 instructions to the opcode decoder/controller. It owns the program counter and issues one read at a time to instruction memory. It predecodes and follows unconditional `B` locally, and presents each fetched word with its PC to the decode stage over a valid/ready handshake. It accepts redirects from downstream conditional-branch resolution (`CBZ`) and discards any wrong-path fetch in flight.

---
 rtl/legv8_pkg.sv | 15 +
 rtl/pc_next_calc.sv | 22 ++
 rtl/instruction_fetch_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end definitions: opcodes, instruction size and fetch FSM states.
package legv8_pkg;

  localparam logic [5:0]  OPC_B       = 6'b000101;
  localparam logic [7:0]  OPC_CBZ     = 8'b10110100;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Predecodes a fetched word: flags unconditional B and computes the PC to fetch next.
module pc_next_calc
  import legv8_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [31:0]       instr_i,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic              is_b_o
);

  logic [ADDR_W-1:0] b_offset;

  always_comb begin
    is_b_o    = (instr_i[31:26] == OPC_B);
    // imm26 is a word offset: sign-extend, then scale to bytes.
    b_offset  = {{(ADDR_W-28){instr_i[25]}}, instr_i[25:0], 2'b00};
    pc_next_o = is_b_o ? (pc_i + b_offset) : (pc_i + ADDR_W'(INSTR_BYTES));
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential LEGv8 fetch front end: one outstanding imem read, local B following,
// valid/ready delivery to decode and redirect handling with wrong-path discard.
module instruction_fetch_unit
  import legv8_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;

  logic [ADDR_W-1:0] calc_pc;
  logic              calc_is_b;
  logic [ADDR_W-1:0] capture_pc;

  pc_next_calc #(
    .ADDR_W (ADDR_W)
  ) u_pc_next_calc (
    .pc_i      (pc_q),
    .instr_i   (imem_rdata),
    .pc_next_o (calc_pc),
    .is_b_o    (calc_is_b)
  );

  assign capture_pc = calc_is_b ? calc_pc : (pc_q + ADDR_W'(INSTR_BYTES));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = 1'b0;
    addr_d  = addr_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;

    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        // With req_q low we are in the first cycle out of reset and nothing is on the bus yet.
        if (req_q) begin
          state_d = redirect_valid ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = imem_rvalid ? FETCH : DROP;
        end else if (imem_rvalid) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          pc_d    = capture_pc;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          pc_d    = redirect_pc;
          state_d = FETCH;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      DROP: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        if (imem_rvalid) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    // Request is registered so it is on the bus for the whole FETCH cycle.
    if (state_d == FETCH) begin
      req_d  = 1'b1;
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;

endmodule
